// File: rtl/tt_um_jimktrains_vslc_sequencer_pkg.sv
// Shared definitions for the VSLC scan sequencer and its instruction executor.
// Holds FSM encoding, memory sizing defaults and opcode-class constants.
package tt_um_jimktrains_vslc_sequencer_pkg;

    localparam int unsigned PROG_DEPTH_DEF = 32;
    localparam int unsigned ADDR_W_DEF     = 5;
    localparam int unsigned INSTR_W        = 8;
    localparam int unsigned STATE_W        = 2;

    localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
    localparam logic [STATE_W-1:0] ST_LOAD = 2'd1;
    localparam logic [STATE_W-1:0] ST_SNAP = 2'd2;
    localparam logic [STATE_W-1:0] ST_EXEC = 2'd3;

    // Opcode class lives in the top three instruction bits; executor decodes the rest.
    localparam int unsigned OPC_CLASS_W = 3;
    localparam logic [OPC_CLASS_W-1:0] OPC_CLASS_LD   = 3'd0;
    localparam logic [OPC_CLASS_W-1:0] OPC_CLASS_AND  = 3'd1;
    localparam logic [OPC_CLASS_W-1:0] OPC_CLASS_OR   = 3'd2;
    localparam logic [OPC_CLASS_W-1:0] OPC_CLASS_XOR  = 3'd3;
    localparam logic [OPC_CLASS_W-1:0] OPC_CLASS_EDGE = 3'd4;
    localparam logic [OPC_CLASS_W-1:0] OPC_CLASS_ST   = 3'd5;
    localparam logic [OPC_CLASS_W-1:0] OPC_CLASS_TMR  = 3'd6;
    localparam logic [OPC_CLASS_W-1:0] OPC_CLASS_SYS  = 3'd7;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic               ready;
    } issue_t;

    function automatic logic [OPC_CLASS_W-1:0] opc_class(input logic [INSTR_W-1:0] i);
        return i[INSTR_W-1 -: OPC_CLASS_W];
    endfunction

endpackage

// File: rtl/tt_um_jimktrains_vslc_progmem.sv
// Program store: one synchronous write port, one combinational read port.
// Contents are deliberately not reset; the sequencer gates use via prog_len.
module tt_um_jimktrains_vslc_progmem
    import tt_um_jimktrains_vslc_sequencer_pkg::*;
#(
    parameter int unsigned DEPTH  = PROG_DEPTH_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic               clk,
    input  logic               we,
    input  logic [ADDR_W-1:0]  waddr,
    input  logic [INSTR_W-1:0] wdata,
    input  logic [ADDR_W-1:0]  raddr,
    output logic [INSTR_W-1:0] rdata_c
);

    logic [INSTR_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_c = mem[raddr];

endmodule

// File: rtl/tt_um_jimktrains_vslc_sequencer.sv
// Scan sequencer: loads a program, then repeatedly snapshots inputs and issues
// one instruction per cycle to the executor, with atomic scans.
module tt_um_jimktrains_vslc_sequencer
    import tt_um_jimktrains_vslc_sequencer_pkg::*;
#(
    parameter int unsigned PROG_DEPTH = PROG_DEPTH_DEF,
    parameter int unsigned ADDR_W     = ADDR_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_en,
    input  logic               load_valid,
    input  logic [INSTR_W-1:0] load_data,
    input  logic               run_en,
    input  logic [7:0]         ui_in,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_ready,
    output logic [7:0]         ui_in_snap,
    output logic [7:0]         ui_in_prev,
    output logic               scan_done,
    output logic               busy,
    output logic [ADDR_W:0]    prog_len,
    output logic               load_overflow
);

    logic [STATE_W-1:0] state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W:0]    wptr_q, wptr_d;
    logic [ADDR_W:0]    prog_len_q, prog_len_d;
    issue_t             issue_q, issue_d;
    logic [7:0]         snap_q, snap_d;
    logic [7:0]         prev_q, prev_d;
    logic               last_q, last_d;
    logic               scan_done_q, scan_done_d;
    logic               ovf_q, ovf_d;
    logic               busy_q, busy_d;

    logic               mem_we_c;
    logic [INSTR_W-1:0] mem_rdata_c;
    logic               mem_space_c;
    logic               pc_last_c;

    tt_um_jimktrains_vslc_progmem #(
        .DEPTH  (PROG_DEPTH),
        .ADDR_W (ADDR_W)
    ) u_progmem (
        .clk     (clk),
        .we      (mem_we_c),
        .waddr   (wptr_q[ADDR_W-1:0]),
        .wdata   (load_data),
        .raddr   (pc_q),
        .rdata_c (mem_rdata_c)
    );

    assign mem_space_c = wptr_q < (ADDR_W+1)'(PROG_DEPTH);
    assign pc_last_c   = (ADDR_W+1)'(pc_q) == (prog_len_q - (ADDR_W+1)'(1));

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        wptr_d      = wptr_q;
        prog_len_d  = prog_len_q;
        issue_d     = '{instr: issue_q.instr, ready: 1'b0};
        snap_d      = snap_q;
        prev_d      = prev_q;
        last_d      = 1'b0;
        scan_done_d = last_q;
        ovf_d       = ovf_q;
        mem_we_c    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (load_en) begin
                    state_d    = ST_LOAD;
                    wptr_d     = '0;
                    prog_len_d = '0;
                    ovf_d      = 1'b0;
                end else if (run_en && (prog_len_q != '0)) begin
                    state_d = ST_SNAP;
                end
            end
            ST_LOAD: begin
                if (!load_en) begin
                    state_d = ST_IDLE;
                end else if (load_valid) begin
                    if (mem_space_c) begin
                        mem_we_c   = 1'b1;
                        wptr_d     = wptr_q + (ADDR_W+1)'(1);
                        prog_len_d = wptr_q + (ADDR_W+1)'(1);
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
            end
            ST_SNAP: begin
                prev_d  = snap_q;
                snap_d  = ui_in;
                pc_d    = '0;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                issue_d = '{instr: mem_rdata_c, ready: 1'b1};
                pc_d    = pc_q + ADDR_W'(1);
                // Mode changes are honoured only once the final instruction is out.
                if (pc_last_c) begin
                    last_d  = 1'b1;
                    state_d = run_en ? ST_SNAP : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_SNAP) || (state_d == ST_EXEC);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pc_q        <= '0;
            wptr_q      <= '0;
            prog_len_q  <= '0;
            issue_q     <= '0;
            snap_q      <= '0;
            prev_q      <= '0;
            last_q      <= 1'b0;
            scan_done_q <= 1'b0;
            ovf_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            wptr_q      <= wptr_d;
            prog_len_q  <= prog_len_d;
            issue_q     <= issue_d;
            snap_q      <= snap_d;
            prev_q      <= prev_d;
            last_q      <= last_d;
            scan_done_q <= scan_done_d;
            ovf_q       <= ovf_d;
            busy_q      <= busy_d;
        end
    end

    assign instr         = issue_q.instr;
    assign instr_ready   = issue_q.ready;
    assign ui_in_snap    = snap_q;
    assign ui_in_prev    = prev_q;
    assign scan_done     = scan_done_q;
    assign busy          = busy_q;
    assign prog_len      = prog_len_q;
    assign load_overflow = ovf_q;

endmodule

// File: tb/tb_tt_um_jimktrains_vslc_sequencer.sv
// Scoreboard bench for the VSLC scan sequencer: stimulus pushes expected issues,
// a negedge monitor pops and compares whenever instr_ready is high.
module tb_tt_um_jimktrains_vslc_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       load_en;
    logic       load_valid;
    logic [7:0] load_data;
    logic       run_en;
    logic [7:0] ui_in;
    logic [7:0] instr;
    logic       instr_ready;
    logic [7:0] ui_in_snap;
    logic [7:0] ui_in_prev;
    logic       scan_done;
    logic       busy;
    logic [5:0] prog_len;
    logic       load_overflow;

    always #5 clk = ~clk;

    tt_um_jimktrains_vslc_sequencer #(
        .PROG_DEPTH (32),
        .ADDR_W     (5)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .load_en       (load_en),
        .load_valid    (load_valid),
        .load_data     (load_data),
        .run_en        (run_en),
        .ui_in         (ui_in),
        .instr         (instr),
        .instr_ready   (instr_ready),
        .ui_in_snap    (ui_in_snap),
        .ui_in_prev    (ui_in_prev),
        .scan_done     (scan_done),
        .busy          (busy),
        .prog_len      (prog_len),
        .load_overflow (load_overflow)
    );

    typedef struct {
        logic [7:0] instr;
        logic [7:0] snap;
        logic [7:0] prev;
        bit         last;
        int         gap;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         last_rdy_cyc = 0;
    bit         prev_last = 1'b0;

    logic [7:0] stim [40];
    logic [7:0] model_mem [32];
    int         model_len = 0;
    logic [7:0] m_snap = 8'h00;
    logic [7:0] m_prev = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, req);
        end
    endtask

    // Monitor: scan_done must follow the last issue of a scan by exactly one cycle.
    always @(negedge clk) begin
        cyc++;
        chk("scan_done", 32'(scan_done), 32'(prev_last));
        prev_last = 1'b0;
        if (instr_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_instr: got 0x%0h with nothing pending", instr);
            end else begin
                mon_e = exp_q.pop_front();
                chk("instr", 32'(instr), 32'(mon_e.instr));
                chk("ui_in_snap", 32'(ui_in_snap), 32'(mon_e.snap));
                chk("ui_in_prev", 32'(ui_in_prev), 32'(mon_e.prev));
                if (mon_e.gap > 0) begin
                    chk("issue_gap", 32'(cyc - last_rdy_cyc), 32'(mon_e.gap));
                end
                prev_last = mon_e.last;
            end
            last_rdy_cyc = cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_stim(input int n);
        load_en = 1'b1;
        tick();
        model_len = 0;
        for (int i = 0; i < n; i++) begin
            load_valid = 1'b1;
            load_data  = stim[i];
            tick();
            if (model_len < 32) begin
                model_mem[model_len] = stim[i];
                model_len++;
            end
        end
        load_valid = 1'b0;
        load_en    = 1'b0;
        tick();
    endtask

    task automatic push_scan(input int n_issue, input logic [7:0] ui, input bit cont);
        exp_t e;
        m_prev = m_snap;
        m_snap = ui;
        for (int i = 0; i < n_issue; i++) begin
            e.instr = model_mem[i];
            e.snap  = m_snap;
            e.prev  = m_prev;
            e.last  = (i == model_len - 1);
            e.gap   = (i == 0) ? (cont ? 2 : -1) : 1;
            exp_q.push_back(e);
        end
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            tick();
            k++;
        end
        chk("pending_issues", 32'(exp_q.size()), 32'd0);
        repeat (3) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1);
    end

    initial begin
        rst        = 1'b1;
        load_en    = 1'b0;
        load_valid = 1'b0;
        load_data  = 8'h00;
        run_en     = 1'b0;
        ui_in      = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_instr", 32'(instr), 32'd0);
        chk("rst_instr_ready", 32'(instr_ready), 32'd0);
        chk("rst_snap", 32'(ui_in_snap), 32'd0);
        chk("rst_prev", 32'(ui_in_prev), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_prog_len", 32'(prog_len), 32'd0);
        chk("rst_overflow", 32'(load_overflow), 32'd0);

        // Empty program blocks execution
        tick();
        run_en = 1'b1;
        repeat (8) tick();
        @(negedge clk);
        chk("empty_busy", 32'(busy), 32'd0);
        chk("empty_prog_len", 32'(prog_len), 32'd0);
        tick();
        run_en = 1'b0;

        // Three-byte program, two continuous scans with changing inputs
        stim[0] = 8'h01; stim[1] = 8'h90; stim[2] = 8'h1F;
        load_stim(3);
        @(negedge clk);
        chk("load3_prog_len", 32'(prog_len), 32'd3);
        chk("load3_overflow", 32'(load_overflow), 32'd0);
        push_scan(3, 8'hA5, 1'b0);
        push_scan(3, 8'h3C, 1'b1);
        tick();
        ui_in  = 8'hA5;
        run_en = 1'b1;
        repeat (3) tick();
        ui_in = 8'h3C;
        repeat (3) tick();
        run_en = 1'b0;
        drain(20);
        @(negedge clk);
        chk("scan2_busy_after", 32'(busy), 32'd0);

        // Mode change mid-scan completes the scan, then enters LOAD
        push_scan(3, 8'h3C, 1'b0);
        tick();
        run_en = 1'b1;
        repeat (3) tick();
        run_en  = 1'b0;
        load_en = 1'b1;
        drain(10);
        @(negedge clk);
        chk("midscan_prog_len_cleared", 32'(prog_len), 32'd0);
        chk("midscan_busy", 32'(busy), 32'd0);

        // 33 bytes into a 32-entry store: last byte dropped
        for (int i = 0; i < 33; i++) stim[i] = 8'(8'h40 + i);
        ui_in = 8'h5A;
        load_stim(33);
        @(negedge clk);
        chk("ovf_prog_len", 32'(prog_len), 32'd32);
        chk("ovf_flag", 32'(load_overflow), 32'd1);
        push_scan(32, 8'h5A, 1'b0);
        tick();
        run_en = 1'b1;
        repeat (3) tick();
        run_en = 1'b0;
        drain(60);

        // Single-instruction program: issue every other cycle
        stim[0] = 8'h77;
        load_stim(1);
        @(negedge clk);
        chk("len1_prog_len", 32'(prog_len), 32'd1);
        chk("len1_overflow_cleared", 32'(load_overflow), 32'd0);
        ui_in = 8'h11;
        push_scan(1, 8'h11, 1'b0);
        push_scan(1, 8'h11, 1'b1);
        push_scan(1, 8'h11, 1'b1);
        tick();
        run_en = 1'b1;
        repeat (5) tick();
        run_en = 1'b0;
        drain(20);

        // Reset in the middle of a scan
        stim[0] = 8'hA0; stim[1] = 8'hA1; stim[2] = 8'hA2;
        load_stim(3);
        ui_in = 8'h22;
        push_scan(1, 8'h22, 1'b0);
        tick();
        run_en = 1'b1;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst    = 1'b0;
        m_snap = 8'h00;
        m_prev = 8'h00;
        @(negedge clk);
        chk("rstexec_instr_ready", 32'(instr_ready), 32'd0);
        chk("rstexec_prev", 32'(ui_in_prev), 32'd0);
        chk("rstexec_snap", 32'(ui_in_snap), 32'd0);
        chk("rstexec_prog_len", 32'(prog_len), 32'd0);
        chk("rstexec_busy", 32'(busy), 32'd0);
        repeat (6) tick();
        run_en = 1'b0;
        @(negedge clk);
        chk("rstexec_idle_busy", 32'(busy), 32'd0);
        chk("final_pending", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tt_um_jimktrains_vslc_sequencer.md
TT_UM_JIMKTRAINS_VSLC_SEQUENCER -- requirements
Module: tt_um_jimktrains_vslc_sequencer

Interface
REQ-001 SHALL have parameter PROG_DEPTH, default 32, number of 8-bit program memory entries.
REQ-002 SHALL have parameter ADDR_W, default 5, equal to log2(PROG_DEPTH).
REQ-003 clk  input  1  sole clock; all state updates on posedge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 load_en  input  1  level; requests program-load mode.
REQ-006 load_valid  input  1  qualifies load_data for one cycle.
REQ-007 load_data  input  8  program byte to store.
REQ-008 run_en  input  1  level; permits continuous scan execution.
REQ-009 ui_in  input  8  live input pins.
REQ-010 instr  output  8  current instruction to the executor.
REQ-011 instr_ready  output  1  instr valid for this cycle only.
REQ-012 ui_in_snap  output  8  inputs latched at the start of the current scan.
REQ-013 ui_in_prev  output  8  inputs latched at the start of the previous scan.
REQ-014 scan_done  output  1  one-cycle pulse after the last instruction of a scan.
REQ-015 busy  output  1  high in SNAP or EXEC.
REQ-016 prog_len  output  ADDR_W+1  number of stored program bytes (0..PROG_DEPTH).
REQ-017 load_overflow  output  1  sticky; a byte was dropped because memory was full.

Function
REQ-018 SHALL implement the states IDLE, LOAD, SNAP and EXEC, all outputs registered.
REQ-019 IDLE: load_en=1 -> LOAD, clearing wptr, prog_len and load_overflow; otherwise run_en=1 and prog_len!=0 -> SNAP; otherwise stay; load_en takes priority.
REQ-020 LOAD: with load_valid=1 and wptr<PROG_DEPTH, SHALL write mem[wptr]<=load_data, increment wptr and set prog_len<=wptr+1.
REQ-021 LOAD: with load_valid=1 and wptr==PROG_DEPTH, SHALL drop the byte and set load_overflow; memory and prog_len stay unchanged.
REQ-022 LOAD: load_en=0 -> IDLE; a load_valid in that same cycle is ignored.
REQ-023 SNAP: SHALL perform ui_in_prev<=ui_in_snap, ui_in_snap<=ui_in, pc<=0, then -> EXEC; duration exactly 1 cycle; instr_ready=0.
REQ-024 EXEC: each cycle SHALL drive instr<=mem[pc], instr_ready<=1, pc<=pc+1; one instruction per cycle, no gaps.
REQ-025 EXEC: after issuing pc==prog_len-1, next state SHALL be SNAP if run_en=1, else IDLE; scan_done pulses in the cycle after the last instr_ready.
REQ-026 A scan SHALL be atomic: load_en and run_en deasserting mid-EXEC take effect only at the end of the scan.
REQ-027 instr SHALL hold its last value while instr_ready=0; the executor samples on negedge, so instr and instr_ready are stable through each whole cycle.
REQ-028 ui_in_snap and ui_in_prev SHALL change only in SNAP, so they are constant across every instruction of a scan.
REQ-029 Scan period SHALL be prog_len+1 cycles; with prog_len=1, instr_ready is high one cycle in every two.
REQ-030 pc SHALL never address beyond prog_len-1; wrap occurs only through SNAP.

Reset
REQ-031 On rst=1 at posedge: state=IDLE; pc, wptr, prog_len, instr, instr_ready, ui_in_snap, ui_in_prev, scan_done and load_overflow SHALL all be 0; rst overrides every other input.
REQ-032 Program memory SHALL NOT be reset; prog_len=0 blocks execution until a reload.
REQ-033 Reset mid-EXEC SHALL drop instr_ready in the following cycle with no scan_done pulse.

Structure
REQ-034 A shared package SHALL hold the state enum encoding, PROG_DEPTH/ADDR_W defaults and the opcode-class constants shared with the executor.
REQ-035 Program memory SHALL be a sub-module tt_um_jimktrains_vslc_progmem with 1 synchronous write port and 1 combinational read port.
REQ-036 SHALL use no latches, no second clock, and no combinational path from inputs to outputs.

Verification
REQ-037 Reset, then run_en=1 with prog_len=0 -> stays IDLE, instr_ready never asserts.
REQ-038 Load 0x01,0x90,0x1F, then run_en=1 -> SNAP, instr 0x01,0x90,0x1F on 3 consecutive cycles, scan_done pulse, SNAP, repeat with period 4.
REQ-039 ui_in=0xA5 during scan 1 and 0x3C during scan 2 -> in scan 2, ui_in_snap=0x3C and ui_in_prev=0xA5, both constant across the scan.
REQ-040 Load 33 bytes -> prog_len=32, load_overflow=1, mem[31] holds byte 32.
REQ-041 Drop run_en and raise load_en at the 2nd instruction of a 3-byte scan -> 3rd instruction issues, scan_done pulses, then LOAD is entered.
REQ-042 Assert rst during EXEC -> next cycle instr_ready=0, ui_in_prev=0, prog_len=0, no scan_done pulse.
